// File: rtl/register_file_ab_pkg.sv
// rtl/register_file_ab_pkg.sv - shared widths, zero-register index and address type for the register file
package register_file_ab_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // Architectural register 0 always reads as zero and is never written.
    localparam int REG_ZERO = 0;

    typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one combinational read port; write-to-read forwarding when REGFILE_BYPASS_EN is defined
module regfile_read_port
    import register_file_ab_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] stored_data_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

`ifndef REGFILE_BYPASS_EN
    // Without forwarding the write port is not looked at.
    logic unused_write_port;
    assign unused_write_port = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    // Stored value, optionally overridden by the in-flight write; the zero check comes last so r0 is never forwarded.
    always_comb begin
        rd_data_o = stored_data_i;
`ifdef REGFILE_BYPASS_EN
        if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end
`endif
        if (rd_addr_i == ADDR_WIDTH'(REG_ZERO)) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/register_file_ab.sv
// rtl/register_file_ab.sv - multicycle-datapath register file with two read ports and A/B operand latches (option: REGFILE_BYPASS_EN)
module register_file_ab
    import register_file_ab_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  LatchAB,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] B
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  wr_valid;

    // A write to r0 is dropped here so neither storage nor forwarding ever sees it.
    assign wr_valid = RegWrite && (WriteReg != ADDR_WIDTH'(REG_ZERO));

    assign regs_q[0] = '0;

    genvar g;
    generate
        for (g = 1; g < NUM_REGS; g++) begin : g_reg
            // One storage entry: cleared by reset, loaded only when addressed by a valid write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_q[g] <= '0;
                end else if (wr_valid && (WriteReg == ADDR_WIDTH'(g))) begin
                    regs_q[g] <= WriteData;
                end
            end
        end
    endgenerate

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port1 (
        .rd_addr_i    (ReadReg1),
        .stored_data_i(regs_q[ReadReg1]),
        .wr_en_i      (wr_valid),
        .wr_addr_i    (WriteReg),
        .wr_data_i    (WriteData),
        .rd_data_o    (ReadData1)
    );

    regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_read_port2 (
        .rd_addr_i    (ReadReg2),
        .stored_data_i(regs_q[ReadReg2]),
        .wr_en_i      (wr_valid),
        .wr_addr_i    (WriteReg),
        .wr_data_i    (WriteData),
        .rd_data_o    (ReadData2)
    );

    // Operand latches take the pre-edge read-port values in the decode cycle, otherwise hold.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (LatchAB) begin
            a_d = ReadData1;
            b_d = ReadData2;
        end
    end

    // Operand latch registers; reset wins over LatchAB.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign A = a_q;
    assign B = b_q;

endmodule

// File: tb/tb_register_file_ab.sv
// tb/tb_register_file_ab.sv - scoreboard bench for register_file_ab (both REGFILE_BYPASS_EN builds)
module tb_register_file_ab;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int SEL_RD1 = 0;
    localparam int SEL_RD2 = 1;
    localparam int SEL_A   = 2;
    localparam int SEL_B   = 3;

    typedef struct {
        string        name;
        int           sel;
        logic [DW-1:0] exp;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ReadReg1, ReadReg2, WriteReg;
    logic [DW-1:0] WriteData;
    logic          RegWrite, LatchAB;
    logic [DW-1:0] ReadData1, ReadData2, A, B;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    register_file_ab dut (
        .clk      (clk),
        .reset    (reset),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .RegWrite (RegWrite),
        .LatchAB  (LatchAB),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2),
        .A        (A),
        .B        (B)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [DW-1:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] val);
        RegWrite  = 1'b1;
        WriteReg  = idx;
        WriteData = val;
        cyc();
        RegWrite  = 1'b0;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            logic [DW-1:0] act;
            e = sb_q.pop_front();
            case (e.sel)
                SEL_RD1: act = ReadData1;
                SEL_RD2: act = ReadData2;
                SEL_A:   act = A;
                default: act = B;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] hz_pre, hz_a;
`ifdef REGFILE_BYPASS_EN
        hz_pre = 32'h0000_000A;
        hz_a   = 32'h0000_000A;
`else
        hz_pre = 32'h0000_0005;
        hz_a   = 32'h0000_0005;
`endif
        reset = 1'b1; RegWrite = 1'b0; LatchAB = 1'b0;
        ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; WriteData = '0;
        cyc();
        reset = 1'b0;
        expect_val("reset_A", SEL_A, 32'h0);
        expect_val("reset_B", SEL_B, 32'h0);
        expect_val("reset_rd1_r0", SEL_RD1, 32'h0);

        do_write(5, 32'h0000_1234);
        ReadReg1 = 5;
        expect_val("preload_r5", SEL_RD1, 32'h0000_1234);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        expect_val("reset_clears_r5", SEL_RD1, 32'h0);
        expect_val("reset2_A", SEL_A, 32'h0);
        expect_val("reset2_B", SEL_B, 32'h0);

        do_write(5, 32'h0000_1234);
        ReadReg2 = 5;
        LatchAB  = 1'b1;
        cyc();
        LatchAB = 1'b0;
        expect_val("latch_r5_B", SEL_B, 32'h0000_1234);
        reset = 1'b1; RegWrite = 1'b1; WriteReg = 5; WriteData = 32'h5555_5555; LatchAB = 1'b1;
        cyc();
        reset = 1'b0; RegWrite = 1'b0; LatchAB = 1'b0;
        expect_val("reset_beats_write", SEL_RD1, 32'h0);
        expect_val("reset_beats_latch_B", SEL_B, 32'h0);

        do_write(7, 32'hDEAD_BEEF);
        ReadReg1 = 7; ReadReg2 = 7;
        expect_val("r7_port1", SEL_RD1, 32'hDEAD_BEEF);
        expect_val("r7_port2", SEL_RD2, 32'hDEAD_BEEF);
        cyc();

        do_write(0, 32'hFFFF_FFFF);
        ReadReg1 = 0; ReadReg2 = 0;
        expect_val("r0_port1", SEL_RD1, 32'h0);
        expect_val("r0_port2", SEL_RD2, 32'h0);
        cyc();

        do_write(3, 32'h11);
        do_write(4, 32'h22);
        ReadReg1 = 3; ReadReg2 = 4; LatchAB = 1'b1;
        cyc();
        LatchAB = 1'b0;
        expect_val("latch_A", SEL_A, 32'h11);
        expect_val("latch_B", SEL_B, 32'h22);
        do_write(3, 32'h99);
        expect_val("hold_A", SEL_A, 32'h11);
        expect_val("hold_B", SEL_B, 32'h22);
        expect_val("r3_new", SEL_RD1, 32'h99);
        cyc();

        do_write(9, 32'h5);
        RegWrite = 1'b1; WriteReg = 9; WriteData = 32'hA; ReadReg1 = 9; LatchAB = 1'b1;
        expect_val("hazard_rd1_pre_edge", SEL_RD1, hz_pre);
        cyc();
        RegWrite = 1'b0; LatchAB = 1'b0;
        expect_val("hazard_A", SEL_A, hz_a);
        expect_val("hazard_r9_after", SEL_RD1, 32'hA);
        cyc();

        RegWrite = 1'b0; WriteReg = 9; WriteData = 32'h0BAD_0BAD;
        cyc();
        expect_val("no_write_when_disabled", SEL_RD1, 32'hA);
        cyc();

        for (int i = 1; i < 32; i++) begin
            do_write(AW'(i), 32'h100 + DW'(i));
        end
        for (int i = 1; i < 32; i++) begin
            ReadReg1 = AW'(i);
            ReadReg2 = AW'(32 - i);
            expect_val($sformatf("sweep_p1_r%0d", i), SEL_RD1, 32'h100 + DW'(i));
            expect_val($sformatf("sweep_p2_r%0d", 32 - i), SEL_RD2, 32'h100 + DW'(32 - i));
            cyc();
        end
        ReadReg1 = 0;
        expect_val("sweep_r0", SEL_RD1, 32'h0);
        cyc();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
